// File: rtl/debounce_pkg.sv
// Shared debounce definitions: FSM state encoding and synchronizer depth.
// Bit 1 of every state encoding equals the debounced level it represents.
package debounce_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        WAIT_LOW    = 2'b10
    } db_state_t;

    function automatic logic level_of(input db_state_t st);
        return (st == STABLE_HIGH) || (st == WAIT_LOW);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; synchronous reset
// clears both stages.
module sync_2ff
    import debounce_pkg::*;
(
    input  logic CLK,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_DEPTH-1:0] stages;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_DEPTH-2:0], async_in};
        end
    end

    assign sync_out = stages[SYNC_DEPTH-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizing debouncer: D follows Din once the synchronized input holds a
// new level for STABLE_CYCLES samples. Edge pulses enabled by DEBOUNCE_PULSE_EN.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic CLK,
    input  logic Reset,
    input  logic Din,
    output logic D,
    output logic Rise,
    output logic Fall
);

    localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             d_q, d_d;

    sync_2ff u_sync (
        .CLK      (CLK),
        .Reset    (Reset),
        .async_in (Din),
        .sync_out (s)
    );

    // count holds the number of consecutive samples already seen at the new
    // level, so the sample that would make it STABLE_CYCLES toggles instead.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            STABLE_LOW: begin
                count_d = '0;
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                    end else begin
                        state_d = WAIT_HIGH;
                        count_d = CNT_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                count_d = '0;
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STABLE_LOW;
                    end else begin
                        state_d = WAIT_LOW;
                        count_d = CNT_W'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                count_d = '0;
            end
        endcase
        d_d = level_of(state_d);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= STABLE_LOW;
            count_q <= '0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d_q     <= d_d;
        end
    end

    assign D = d_q;

`ifdef DEBOUNCE_PULSE_EN
    logic rise_q, fall_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= d_d & ~d_q;
            fall_q <= ~d_d & d_q;
        end
    end

    assign Rise = rise_q;
    assign Fall = fall_q;
`else
    assign Rise = 1'b0;
    assign Fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync (STABLE_CYCLES=4): directed scenarios
// plus randomized Din runs against a run-length reference model.
module tb_debounce_sync;

    localparam int unsigned STABLE = 4;
`ifdef DEBOUNCE_PULSE_EN
    localparam bit PULSE_ON = 1'b1;
`else
    localparam bit PULSE_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    logic Din = 1'b0;
    logic D, Rise, Fall;

    int checks = 0;
    int errors = 0;

    // Reference model: Din samples delayed two edges, and a run of samples
    // differing from the current level.
    logic        sq[$];
    logic        m_d, m_rise, m_fall;
    int unsigned m_run;

    debounce_sync #(.STABLE_CYCLES(STABLE)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .Din   (Din),
        .D     (D),
        .Rise  (Rise),
        .Fall  (Fall)
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic din_v, input logic rst_v);
        logic s;
        if (rst_v) begin
            sq = {1'b0, 1'b0};
            m_d = 1'b0; m_run = 0; m_rise = 1'b0; m_fall = 1'b0;
        end else begin
            s = sq.pop_front();
            sq.push_back(din_v);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s != m_d) m_run++;
            else m_run = 0;
            if (m_run == STABLE) begin
                m_d = ~m_d;
                m_run = 0;
                m_rise = PULSE_ON & m_d;
                m_fall = PULSE_ON & ~m_d;
            end
        end
    endtask

    task automatic step(input logic din_v, input logic rst_v);
        @(negedge CLK);
        Din = din_v;
        Reset = rst_v;
        @(posedge CLK);
        model_edge(din_v, rst_v);
        #1;
        chk("model_d", D, m_d);
        chk("model_rise", Rise, m_rise);
        chk("model_fall", Fall, m_fall);
        chk("rise_fall_exclusive", Rise & Fall, 1'b0);
    endtask

    initial begin
        int unsigned len;
        logic        v;

        // Reset held two edges with Din high, then release.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            chk("reset_d", D, 1'b0);
            chk("reset_rise", Rise, 1'b0);
            chk("reset_fall", Fall, 1'b0);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0);
            chk("release_d", D, i >= 6);
            chk("release_rise", Rise, PULSE_ON && i == 6);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0);
            chk("release_low_d", D, i < 6);
            chk("release_low_fall", Fall, PULSE_ON && i == 6);
        end

        // Clean press held 200 ns.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            chk("press_d", D, i >= 6);
            chk("press_rise", Rise, PULSE_ON && i == 6);
            chk("press_fall", Fall, 1'b0);
        end
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0);
        chk("press_back_low", D, 1'b0);

        // Bounce 1,0,1,0 then settle high.
        for (int i = 0; i < 4; i++) begin
            step((i % 2) == 0, 1'b0);
            chk("bounce_d", D, 1'b0);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            chk("bounce_settle_d", D, i >= 6);
            chk("bounce_settle_rise", Rise, PULSE_ON && i == 6);
        end
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0);

        // Glitch of 3 cycles is rejected.
        for (int i = 1; i <= 13; i++) begin
            step(i <= 3, 1'b0);
            chk("glitch_d", D, 1'b0);
            chk("glitch_rise", Rise, 1'b0);
        end

        // Reset on the third WAIT_LOW cycle drops the pending fall.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0);
        chk("midwait_high", D, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0);
            chk("midwait_hold_d", D, 1'b1);
        end
        step(1'b0, 1'b1);
        chk("midwait_reset_d", D, 1'b0);
        chk("midwait_reset_fall", Fall, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0);
            chk("midwait_after_d", D, 1'b0);
            chk("midwait_after_fall", Fall, 1'b0);
        end

        // Randomized runs with occasional resets.
        for (int n = 0; n < 120; n++) begin
            len = $urandom_range(1, 9);
            v = 1'($urandom_range(0, 1));
            for (int unsigned k = 0; k < len; k++) begin
                step(v, ($urandom_range(0, 79) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
